// File: rtl/loading_percent_display.sv
// Converts a 0..127 loading percentage into three seven-segment digits and a
// ten-segment thermometer bar using a serial double-dabble binary-to-BCD pass.
module loading_percent_display #(
    parameter int MAX_PCT       = 100,
    parameter int BLANK_LEADING = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] in_port,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic [9:0] bar,
    output logic       done,
    output logic       clamped,
    output logic       busy
);

    localparam logic [6:0] MAX7     = 7'(MAX_PCT);
    localparam logic [6:0] SEG_ZERO = 7'h40;
    localparam logic [6:0] SEG_BLNK = 7'h7F;
    localparam logic [6:0] LEAD_RST = (BLANK_LEADING != 0) ? SEG_BLNK : SEG_ZERO;

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_start;
    logic        w_clamp_in;
    logic [6:0]  w_load_val;
    logic [11:0] w_bcd_adj;
    logic [3:0]  w_hund;
    logic [3:0]  w_tens;
    logic [3:0]  w_unit;

    logic [6:0]  r_pct_s;
    logic [6:0]  r_last_pct;
    logic [6:0]  r_bin;
    logic [6:0]  r_val;
    logic [11:0] r_bcd;
    logic [2:0]  r_cnt;
    logic        r_clamp_pend;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] bar_fill(input logic [3:0] n);
        logic [9:0] f;
        for (int i = 0; i < 10; i++) begin
            f[i] = (i < int'(n));
        end
        return f;
    endfunction

    function automatic logic [3:0] dabble(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    assign w_clamp_in = (r_pct_s > MAX7);
    assign w_load_val = w_clamp_in ? MAX7 : r_pct_s;
    assign w_bcd_adj  = {dabble(r_bcd[11:8]), dabble(r_bcd[7:4]), dabble(r_bcd[3:0])};
    assign w_hund     = r_bcd[11:8];
    assign w_tens     = r_bcd[7:4];
    assign w_unit     = r_bcd[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pct_s != r_last_pct) begin
                    w_start     = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == 3'd6) begin
                    w_state_nxt = UPDATE;
                end
            end
            UPDATE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Control and registered outputs; everything here is cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pct_s      <= 7'd0;
            r_last_pct   <= 7'd0;
            r_cnt        <= 3'd0;
            r_clamp_pend <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            clamped      <= 1'b0;
            bar          <= 10'd0;
            hex0         <= SEG_ZERO;
            hex1         <= LEAD_RST;
            hex2         <= LEAD_RST;
        end else begin
            r_pct_s <= in_port;
            if (w_start) begin
                r_last_pct   <= r_pct_s;
                r_cnt        <= 3'd0;
                r_clamp_pend <= w_clamp_in;
                busy         <= 1'b1;
            end
            if (r_state == SHIFT) begin
                r_cnt <= r_cnt + 3'd1;
            end
            if (r_state == UPDATE) begin
                busy    <= 1'b0;
                done    <= (r_val == MAX7);
                clamped <= r_clamp_pend;
                bar     <= (w_hund != 4'd0) ? 10'h3FF : bar_fill(w_tens);
                hex0    <= seg7(w_unit);
                hex1    <= ((BLANK_LEADING != 0) && (w_hund == 4'd0) && (w_tens == 4'd0))
                           ? SEG_BLNK : seg7(w_tens);
                hex2    <= ((BLANK_LEADING != 0) && (w_hund == 4'd0)) ? SEG_BLNK : seg7(w_hund);
            end
        end
    end

    // Datapath: shift register and captured value need no reset
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_bin <= w_load_val;
            r_val <= w_load_val;
            r_bcd <= 12'd0;
        end else if (r_state == SHIFT) begin
            r_bcd <= {w_bcd_adj[10:0], r_bin[6]};
            r_bin <= {r_bin[5:0], 1'b0};
        end
    end

endmodule

// File: doc/loading_percent_display.md
LOADING_PERCENT_DISPLAY -- requirements
Module: loading_percent_display

Interface
REQ-001 Parameter: MAX_PCT, 100, clamp ceiling for displayed percentage.
REQ-002 Parameter: BLANK_LEADING, 1, 1 = blank leading-zero hundreds/tens digits; 0 = show all three digits.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_port  input  7  loading percentage from the upstream PIO out_port, unsigned.
REQ-006 Port: hex2  output  7  hundreds digit, active-low segments {g,f,e,d,c,b,a}.
REQ-007 Port: hex1  output  7  tens digit, same encoding.
REQ-008 Port: hex0  output  7  units digit, same encoding.
REQ-009 Port: bar  output  10  thermometer bar, bar[i]=1 for i < lit count.
REQ-010 Port: done  output  1  high while displayed value equals MAX_PCT.
REQ-011 Port: clamped  output  1  high while displayed value came from in_port > MAX_PCT.
REQ-012 Port: busy  output  1  high while a conversion is in progress.

Function
REQ-013 in_port SHALL be registered into pct_s every cycle; no other logic reads in_port directly.
REQ-014 FSM states SHALL be IDLE, SHIFT, UPDATE; reset state IDLE.
REQ-015 IDLE: if pct_s != last_pct, next edge SHALL load shift register with min(pct_s, MAX_PCT), clear BCD register and bit counter, set last_pct <= pct_s, set busy, go to SHIFT; else stay IDLE.
REQ-016 SHIFT: each edge SHALL apply add-3 to every BCD nibble >= 5, then shift {bcd, bin} left one bit; after exactly 7 shifts go to UPDATE.
REQ-017 UPDATE: one edge SHALL register hex2/hex1/hex0, bar, done, clamped from the final BCD, clear busy, return to IDLE.
REQ-018 Latency: outputs SHALL update on the 10th rising edge after in_port changes (1 sample + 1 load + 7 shift + 1 update).
REQ-019 in_port changes while busy SHALL NOT abort the conversion; on return to IDLE a mismatch SHALL start a new conversion (last value wins; intermediate values may never display).
REQ-020 Values > MAX_PCT SHALL display MAX_PCT, with clamped=1; clamped=0 otherwise.
REQ-021 Segment codes (hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; blank=7F.
REQ-022 With BLANK_LEADING=1: hex2 blank when hundreds=0; hex1 blank when hundreds=0 and tens=0; hex0 never blank.
REQ-023 bar lit count SHALL equal floor(displayed/10), i.e. tens digit, or 10 when hundreds=1.
REQ-024 done SHALL be 1 iff displayed value == MAX_PCT.
REQ-025 All outputs SHALL be registered and change only on the UPDATE edge (busy also on the load edge).

Reset
REQ-026 reset SHALL override all activity, including mid-conversion, and on the same edge set: state IDLE, pct_s=0, last_pct=0, busy=0, done=0, clamped=0, bar=0, hex0=40, hex1=hex2=7F (40 if BLANK_LEADING=0).
REQ-027 After reset with in_port=0 no conversion SHALL start; first conversion starts only when in_port becomes nonzero.

Verification
REQ-028 in_port=42 after reset -> 10 edges later hex2=7F, hex1=19, hex0=24, bar=00F, done=0, clamped=0; busy high for edges 2..9.
REQ-029 in_port=100 -> hex2=79, hex1=40, hex0=40, bar=3FF, done=1, clamped=0.
REQ-030 in_port=127 -> same display as 100, done=1, clamped=1.
REQ-031 in_port=42, then 7 three edges later -> first conversion completes showing 42, immediately followed by reconversion; final hex2=7F, hex1=7F, hex0=78, bar=000.
REQ-032 in_port=5 with BLANK_LEADING=0 -> hex2=40, hex1=40, hex0=12; with BLANK_LEADING=1 -> hex2=7F, hex1=7F.
REQ-033 reset asserted during SHIFT of a conversion of 88 -> next edge all outputs at reset values, busy=0; after release, conversion of 88 restarts and completes 10 edges later showing hex1=00, hex0=00.
